sys_tick_master: RTL and testbench
==================================

# sys_tick_master

Avalon-MM initiator that drives the system interval timer from the other side of its 16-bit register bus and services its interrupt. It programs the timer period and starts it in continuous, interrupt-enabled mode. On each timer interrupt it reads status, acknowledges the timeout, and emits a one-cycle system tick with a 32-bit tick count. It sits between the timer slave and the fabric logic that needs a periodic heartbeat without CPU involvement.

## Interface
- PERIOD, 48000, timer period in clocks, 1..2^32; the load value written is PERIOD-1 (default load 47999 = 0x0000_BB7F).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = timer should run, 0 = timer should be stopped.
- timer_address  out  3  register address to timer.
- timer_chipselect  out  1  bus cycle active.
- timer_write_n  out  1  0 = write, 1 = read (valid when chipselect=1).
- timer_writedata  out  16  write data.
- timer_readdata  in  16  timer read data, valid the cycle after the read address is presented.
- timer_irq  in  1  timer interrupt, level.
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  32  serviced timeouts since reset, wraps 0xFFFF_FFFF -> 0.
- restart_count  out  8  times the timer was found stopped and restarted; saturates at 255.
- running  out  1  1 while in RUN or servicing.

## Operation
- Timer register map: 0 status (bit0 TO, bit1 RUN; any write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h.
- Every bus cycle lasts exactly one clock. The timer has no wait-state, so chipselect is high for one cycle per access.
- States and transitions:
  - IDLE: bus idle. Goes to WR_PL when enable=1.
  - WR_PL: write addr 2, data (PERIOD-1)[15:0].
  - WR_PH: write addr 3, data (PERIOD-1)[31:16].
  - WR_CTRL: write addr 1, data 0x0007 (ITO|CONT|START). Goes to RUN.
  - RUN: bus idle. If enable=0, go to WR_STOP. Otherwise, if timer_irq=1, go to RD_STAT. enable has priority over irq.
  - RD_STAT: read addr 0 (chipselect=1, write_n=1).
  - RD_WAIT: bus idle; capture timer_readdata into stat. If stat[0]=0 (spurious irq), go to RUN. Otherwise go to WR_CLR.
  - WR_CLR: write addr 0, data 0. In this cycle assert tick and increment tick_count. Next state is WR_CTRL if stat[1]=0, with restart_count incremented (saturating); otherwise RUN.
  - WR_STOP: write addr 1, data 0x0008 (STOP, ITO/CONT cleared). Goes to IDLE.
- Outside write cycles, timer_writedata holds 0 and timer_address holds 0.
- running = 1 in RUN, RD_STAT, RD_WAIT, WR_CLR and WR_CTRL-after-restart.
- enable falling during init or service does not abort the sequence; it is honoured at the next RUN.

## Timing
- Reset values: timer_chipselect=0, timer_write_n=1, timer_address=0, timer_writedata=0, tick=0, tick_count=0, restart_count=0, running=0, state IDLE. All bus outputs are registered.
- Init: enable sampled 1 in IDLE at edge T. Writes occur in cycles T+1 (addr 2), T+2 (addr 3), T+3 (addr 1). RUN is entered at T+4.
- Service latency: irq sampled 1 in RUN at edge T. Read in cycle T+1, capture in T+2, clear write plus tick in T+3, back in RUN at T+4.
- The timer drops irq the cycle after WR_CLR, so RUN never re-services the same timeout. A timeout arriving in the WR_CLR cycle is lost, because status write has priority in the timer; PERIOD >= 5 avoids this.
- Reset asserted mid-sequence returns all outputs to reset values immediately and abandons any bus cycle.

## Test plan
- Reset, enable=1, PERIOD=48000 -> writes (2,0xBB7F), (3,0x0000), (1,0x0007) on three consecutive cycles, then running=1.
- Free-running with PERIOD=100 for 1000 cycles -> tick pulses spaced 100 clocks apart, tick_count=9 or 10 consistent with first-tick phase, irq low after each clear.
- irq forced high with readdata status=0x0002 (TO=0) -> no tick, no status write, returns to RUN.
- Status read returns 0x0001 (TO=1, RUN=0) -> clear write, tick, then control write 0x0007, restart_count=1; 300 repeats -> restart_count=255.
- enable dropped in RUN -> single write (1,0x0008), running=0, IDLE; enable dropped during RD_WAIT -> service completes with a tick, then stop write.
- tick_count preset near 0xFFFF_FFFF via forced state -> next tick wraps to 0; reset_n pulsed low mid-WR_PH -> chipselect=0 at once, init restarts from WR_PL.

Source files
------------

// File: rtl/sys_tick_master.sv
// sys_tick_master: Avalon-MM initiator that programs the interval timer,
// services its timeout interrupt and turns each serviced timeout into a
// one-cycle system tick with a running 32-bit count.
module sys_tick_master #(
    parameter longint unsigned PERIOD          = 64'd48000,
    // Value tick_count takes on reset; 0 in normal use.
    parameter logic [31:0]     TICK_COUNT_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [2:0]  timer_address,
    output logic        timer_chipselect,
    output logic        timer_write_n,
    output logic [15:0] timer_writedata,
    input  logic [15:0] timer_readdata,
    input  logic        timer_irq,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic [7:0]  restart_count,
    output logic        running
);

    // Timer is loaded with PERIOD-1 so a full period spans PERIOD clocks.
    localparam logic [31:0] LOAD = 32'(PERIOD - 64'd1);

    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_PERL    = 3'd2;
    localparam logic [2:0]  ADDR_PERH    = 3'd3;
    localparam logic [15:0] CTRL_START   = 16'h0007;
    localparam logic [15:0] CTRL_STOP    = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_PL   = 4'd1,
        S_WR_PH   = 4'd2,
        S_WR_CTRL = 4'd3,
        S_RUN     = 4'd4,
        S_RD_STAT = 4'd5,
        S_RD_WAIT = 4'd6,
        S_WR_CLR  = 4'd7,
        S_WR_STOP = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_stat_run;
    logic        r_cs;
    logic        r_wn;
    logic [2:0]  r_addr;
    logic [15:0] r_wd;
    logic        r_tick;
    logic [31:0] r_tick_count;
    logic [7:0]  r_restart_count;
    logic        r_running;

    logic        w_cs;
    logic        w_wn;
    logic [2:0]  w_addr;
    logic [15:0] w_wd;
    logic        w_tick;
    logic        w_restart;
    logic        w_running;
    logic        w_unused_rd;

    // Only TO and RUN of the status word matter here.
    assign w_unused_rd = ^timer_readdata[15:2];

    // Next-state decision plus bus/tick values for the state being entered,
    // so that every output can be registered and still line up with its state.
    always_comb begin
        w_next    = r_state;
        w_cs      = 1'b0;
        w_wn      = 1'b1;
        w_addr    = 3'd0;
        w_wd      = 16'h0000;
        w_tick    = 1'b0;
        w_restart = 1'b0;
        w_running = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next = S_WR_PL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WR_PL:   w_next = S_WR_PH;
            S_WR_PH:   w_next = S_WR_CTRL;
            S_WR_CTRL: w_next = S_RUN;
            S_RUN: begin
                // Stopping wins over servicing a pending interrupt.
                if (!enable) begin
                    w_next = S_WR_STOP;
                end else if (timer_irq) begin
                    w_next = S_RD_STAT;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_RD_STAT: w_next = S_RD_WAIT;
            S_RD_WAIT: begin
                // TO clear means the interrupt was spurious: nothing to ack.
                if (timer_readdata[0]) begin
                    w_next = S_WR_CLR;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_WR_CLR: begin
                // Timer found stopped: reprogram control to restart it.
                if (!r_stat_run) begin
                    w_next    = S_WR_CTRL;
                    w_restart = 1'b1;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_WR_STOP: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase

        case (w_next)
            S_WR_PL: begin
                w_cs   = 1'b1;
                w_wn   = 1'b0;
                w_addr = ADDR_PERL;
                w_wd   = LOAD[15:0];
            end
            S_WR_PH: begin
                w_cs   = 1'b1;
                w_wn   = 1'b0;
                w_addr = ADDR_PERH;
                w_wd   = LOAD[31:16];
            end
            S_WR_CTRL: begin
                w_cs   = 1'b1;
                w_wn   = 1'b0;
                w_addr = ADDR_CONTROL;
                w_wd   = CTRL_START;
            end
            S_RD_STAT: begin
                w_cs   = 1'b1;
                w_wn   = 1'b1;
                w_addr = ADDR_STATUS;
            end
            S_WR_CLR: begin
                w_cs   = 1'b1;
                w_wn   = 1'b0;
                w_addr = ADDR_STATUS;
                w_tick = 1'b1;
            end
            S_WR_STOP: begin
                w_cs   = 1'b1;
                w_wn   = 1'b0;
                w_addr = ADDR_CONTROL;
                w_wd   = CTRL_STOP;
            end
            default: begin
                w_cs = 1'b0;
            end
        endcase

        // A control write is only "running" when it is a restart.
        case (w_next)
            S_RUN, S_RD_STAT, S_RD_WAIT, S_WR_CLR: w_running = 1'b1;
            default:                               w_running = w_restart;
        endcase
    end

    // State register, captured TIMER RUN bit and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_stat_run <= 1'b0;
            r_cs       <= 1'b0;
            r_wn       <= 1'b1;
            r_addr     <= 3'd0;
            r_wd       <= 16'h0000;
            r_tick     <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_RD_WAIT) begin
                r_stat_run <= timer_readdata[1];
            end
            r_cs      <= w_cs;
            r_wn      <= w_wn;
            r_addr    <= w_addr;
            r_wd      <= w_wd;
            r_tick    <= w_tick;
            r_running <= w_running;
        end
    end

    // Tick counter (wrapping) and restart counter (saturating at 255).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_count    <= TICK_COUNT_INIT;
            r_restart_count <= 8'd0;
        end else begin
            if (w_tick) begin
                r_tick_count <= r_tick_count + 32'd1;
            end
            if (w_restart && (r_restart_count != 8'hFF)) begin
                r_restart_count <= r_restart_count + 8'd1;
            end
        end
    end

    assign timer_chipselect = r_cs;
    assign timer_write_n    = r_wn;
    assign timer_address    = r_addr;
    assign timer_writedata  = r_wd;
    assign tick             = r_tick;
    assign tick_count       = r_tick_count;
    assign restart_count    = r_restart_count;
    assign running          = r_running;

endmodule

// File: tb/tb_sys_tick_master.sv
// Bench for sys_tick_master: instance A (PERIOD=48000) is driven with
// directed irq/readdata vectors; instance B (PERIOD=100, tick count preset
// near wrap) runs against a small behavioural interval-timer model.
module tb_sys_tick_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic        rst_a, en_a, irq_a;
    logic [15:0] rd_a;
    logic [2:0]  addr_a;
    logic        cs_a, wn_a, tick_a, run_a;
    logic [15:0] wd_a;
    logic [31:0] cnt_a;
    logic [7:0]  rcnt_a;

    // Instance B signals
    logic        rst_b, en_b, irq_b;
    logic [15:0] rd_b;
    logic [2:0]  addr_b;
    logic        cs_b, wn_b, tick_b, run_b;
    logic [15:0] wd_b;
    logic [31:0] cnt_b;
    logic [7:0]  rcnt_b;

    sys_tick_master dut_a (
        .clk(clk), .reset_n(rst_a), .enable(en_a),
        .timer_address(addr_a), .timer_chipselect(cs_a), .timer_write_n(wn_a),
        .timer_writedata(wd_a), .timer_readdata(rd_a), .timer_irq(irq_a),
        .tick(tick_a), .tick_count(cnt_a), .restart_count(rcnt_a), .running(run_a)
    );

    sys_tick_master #(.PERIOD(64'd100), .TICK_COUNT_INIT(32'hFFFF_FFFE)) dut_b (
        .clk(clk), .reset_n(rst_b), .enable(en_b),
        .timer_address(addr_b), .timer_chipselect(cs_b), .timer_write_n(wn_b),
        .timer_writedata(wd_b), .timer_readdata(rd_b), .timer_irq(irq_b),
        .tick(tick_b), .tick_count(cnt_b), .restart_count(rcnt_b), .running(run_b)
    );

    // Behavioural interval timer behind instance B
    logic [31:0] t_period, t_cnt;
    logic        t_to, t_run, t_ito, t_cont;
    logic        t_wr, t_clr_wr, t_start_wr;
    assign t_wr       = cs_b && !wn_b;
    assign t_clr_wr   = t_wr && (addr_b == 3'd0);
    assign t_start_wr = t_wr && (addr_b == 3'd1) && wd_b[2];
    assign irq_b      = t_to && t_ito;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            t_period <= 32'd0; t_cnt <= 32'd0; t_to <= 1'b0; t_run <= 1'b0;
            t_ito <= 1'b0; t_cont <= 1'b0; rd_b <= 16'h0000;
        end else begin
            if (t_run && !t_start_wr) begin
                if (t_cnt == 32'd0) begin
                    if (!t_clr_wr) t_to <= 1'b1;
                    t_cnt <= t_period;
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
            if (t_wr) begin
                case (addr_b)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= wd_b[0];
                        t_cont <= wd_b[1];
                        if (wd_b[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
                        if (wd_b[3]) t_run <= 1'b0;
                    end
                    3'd2: t_period[15:0]  <= wd_b;
                    3'd3: t_period[31:16] <= wd_b;
                    default: ;
                endcase
            end
            if (cs_b && wn_b) rd_b <= {14'd0, t_run, t_to};
        end
    end

    function automatic logic [31:0] bus(input logic c, input logic w,
                                        input logic [2:0] a, input logic [15:0] d);
        return {11'd0, c, w, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          n_b;
    int          last_b;
    logic        prev_tick_b;
    logic [31:0] exp_b;

    initial begin
        rst_a = 1'b0; en_a = 1'b0; irq_a = 1'b0; rd_a = 16'h0000;
        rst_b = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_bus",     bus(cs_a, wn_a, addr_a, wd_a), bus(1'b0, 1'b1, 3'd0, 16'h0000));
        chk("rst_tick",    {31'd0, tick_a}, 32'd0);
        chk("rst_count",   cnt_a, 32'd0);
        chk("rst_restart", {24'd0, rcnt_a}, 32'd0);
        chk("rst_running", {31'd0, run_a}, 32'd0);
        rst_a = 1'b1; rst_b = 1'b1;

        // Instance B: free-running PERIOD=100 for 1000 cycles
        @(negedge clk);
        en_b = 1'b1;
        n_b = 0; last_b = 0; prev_tick_b = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (prev_tick_b) chk("b_irq_low_after_clr", {31'd0, irq_b}, 32'd0);
            if (tick_b) begin
                n_b++;
                exp_b = 32'hFFFF_FFFE + 32'(n_b);
                chk("b_tick_count", cnt_b, exp_b);
                if (n_b > 1) chk("b_tick_spacing", 32'(c - last_b), 32'd100);
                last_b = c;
            end
            prev_tick_b = tick_b;
        end
        chk("b_ntick_9_or_10", {31'd0, (n_b == 9) || (n_b == 10)}, 32'd1);
        chk("b_restart", {24'd0, rcnt_b}, 32'd0);
        en_b = 1'b0;

        // Instance A: init writes
        en_a = 1'b1;
        @(negedge clk);
        chk("init_wr_pl", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd2, 16'hBB7F));
        chk("init_running0", {31'd0, run_a}, 32'd0);
        @(negedge clk);
        chk("init_wr_ph", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd3, 16'h0000));
        @(negedge clk);
        chk("init_wr_ctrl", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd1, 16'h0007));
        chk("init_ctrl_running0", {31'd0, run_a}, 32'd0);
        @(negedge clk);
        chk("run_bus_idle", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b0, 1'b1, 3'd0, 16'h0000));
        chk("run_running1", {31'd0, run_a}, 32'd1);

        // Spurious interrupt (TO=0)
        irq_a = 1'b1;
        @(negedge clk);
        chk("spur_rd_stat", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b1, 3'd0, 16'h0000));
        irq_a = 1'b0; rd_a = 16'h0002;
        @(negedge clk);
        chk("spur_rd_wait_idle", {31'd0, cs_a}, 32'd0);
        @(negedge clk);
        chk("spur_no_write", {31'd0, cs_a}, 32'd0);
        chk("spur_no_tick", {31'd0, tick_a}, 32'd0);
        chk("spur_count", cnt_a, 32'd0);
        rd_a = 16'h0000;

        // Normal service, timer still running
        irq_a = 1'b1;
        @(negedge clk);
        irq_a = 1'b0; rd_a = 16'h0003;
        @(negedge clk);
        @(negedge clk);
        chk("svc_clr_write", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd0, 16'h0000));
        chk("svc_tick", {31'd0, tick_a}, 32'd1);
        chk("svc_count", cnt_a, 32'd1);
        @(negedge clk);
        chk("svc_back_run", bus({31'd0, tick_a} == 32'd0, cs_a, 3'd0, {15'd0, run_a}),
            bus(1'b1, 1'b0, 3'd0, 16'h0001));

        // Service with timer found stopped -> restart
        irq_a = 1'b1;
        @(negedge clk);
        irq_a = 1'b0; rd_a = 16'h0001;
        @(negedge clk);
        @(negedge clk);
        chk("rst_svc_tick", {31'd0, tick_a}, 32'd1);
        chk("rst_svc_count", cnt_a, 32'd2);
        @(negedge clk);
        chk("restart_ctrl", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd1, 16'h0007));
        chk("restart_count1", {24'd0, rcnt_a}, 32'd1);
        chk("restart_running", {31'd0, run_a}, 32'd1);
        @(negedge clk);
        chk("restart_back_run", {31'd0, cs_a}, 32'd0);
        for (int i = 0; i < 299; i++) begin
            irq_a = 1'b1;
            @(negedge clk);
            irq_a = 1'b0; rd_a = 16'h0001;
            repeat (4) @(negedge clk);
        end
        chk("restart_saturate", {24'd0, rcnt_a}, 32'd255);
        chk("restart_loop_count", cnt_a, 32'd301);
        rd_a = 16'h0000;

        // enable dropped in RUN
        en_a = 1'b0;
        @(negedge clk);
        chk("stop_write", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd1, 16'h0008));
        chk("stop_running0", {31'd0, run_a}, 32'd0);
        @(negedge clk);
        chk("idle_after_stop", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b0, 1'b1, 3'd0, 16'h0000));
        @(negedge clk);
        chk("idle_hold", {30'd0, cs_a, run_a}, 32'd0);

        // Re-init, then enable dropped during RD_WAIT
        en_a = 1'b1;
        repeat (4) @(negedge clk);
        chk("reinit_running", {31'd0, run_a}, 32'd1);
        irq_a = 1'b1;
        @(negedge clk);
        irq_a = 1'b0; rd_a = 16'h0003;
        @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        chk("late_stop_tick", {31'd0, tick_a}, 32'd1);
        chk("late_stop_count", cnt_a, 32'd302);
        @(negedge clk);
        chk("late_stop_run", {30'd0, cs_a, run_a}, 32'd1);
        @(negedge clk);
        chk("late_stop_write", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd1, 16'h0008));
        @(negedge clk);
        chk("late_stop_idle", {30'd0, cs_a, run_a}, 32'd0);
        rd_a = 16'h0000;

        // Reset pulsed mid WR_PH
        en_a = 1'b1;
        @(negedge clk);
        chk("rwp_wr_pl", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd2, 16'hBB7F));
        @(negedge clk);
        chk("rwp_wr_ph", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd3, 16'h0000));
        rst_a = 1'b0;
        #1;
        chk("rwp_async_bus", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b0, 1'b1, 3'd0, 16'h0000));
        chk("rwp_async_count", cnt_a, 32'd0);
        chk("rwp_async_restart", {24'd0, rcnt_a}, 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("rwp_restart_wr_pl", bus(cs_a, wn_a, addr_a, wd_a), bus(1'b1, 1'b0, 3'd2, 16'hBB7F));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
